// File: rtl/recon_frame_store_if.sv
// Bus between the intra reconstruction stage, the prediction stage and the
// reconstructed-frame store: block input, 4x4 neighbour output and readback.
interface recon_frame_store_if #(
  parameter int BIT_LENGTH = 15,
  parameter int LENGTH     = 16,
  parameter int WIDTH      = 16
);
  localparam int AW = $clog2(LENGTH*WIDTH);

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          mb      [15:0];
  logic                nb_valid;
  logic [7:0]          nb_top  [7:0];
  logic [7:0]          nb_left [4:0];
  logic [BIT_LENGTH:0] blk_row;
  logic [BIT_LENGTH:0] blk_col;
  logic                frame_done;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [7:0]          rd_data;

  modport master (
    output in_valid, mb, rd_en, rd_addr,
    input  in_ready, nb_valid, nb_top, nb_left, blk_row, blk_col, frame_done, rd_data
  );

  modport slave (
    input  in_valid, mb, rd_en, rd_addr,
    output in_ready, nb_valid, nb_top, nb_left, blk_row, blk_col, frame_done, rd_data
  );
endinterface

// File: rtl/recon_frame_store.sv
// Reconstructed-frame store: writes 4x4 blocks in raster order, serves the 13
// H.264 intra 4x4 neighbours of the next block and a registered readback port.
module recon_frame_store #(
  parameter int BIT_LENGTH = 15,
  parameter int LENGTH     = 16,
  parameter int WIDTH      = 16,
  parameter int MB_SIZE_L  = 4,
  parameter int MB_SIZE_W  = 4
) (
  input logic             clk,
  input logic             reset,
  recon_frame_store_if.slave bus
);
  localparam int CW   = BIT_LENGTH + 1;
  localparam int AW   = $clog2(LENGTH*WIDTH);
  localparam int COLS = LENGTH / MB_SIZE_W;
  localparam int ROWS = WIDTH / MB_SIZE_L;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [7:0]    NA       = 8'h80;

  typedef enum logic [1:0] {S_NB, S_WAIT, S_WRITE, S_ADV} state_t;

  state_t        state, state_nxt;
  logic [1:0]    wr_r;
  logic [CW-1:0] blk_row, blk_col;
  logic [7:0]    blk_q   [15:0];
  logic [7:0]    top_d   [7:0];
  logic [7:0]    left_d  [4:0];
  logic [7:0]    top_q   [7:0];
  logic [7:0]    left_q  [4:0];
  logic [7:0]    rd_q;
  logic [7:0]    mem     [LENGTH*WIDTH];
  logic          accept, last_col, last_row;
  logic          in_ready, nb_valid, frame_done;
  int            y0, x0;

  function automatic logic [AW-1:0] pix_addr(input int y, input int x);
    return AW'(y*LENGTH + x);
  endfunction

  assign y0       = int'(blk_row) * MB_SIZE_L;
  assign x0       = int'(blk_col) * MB_SIZE_W;
  assign last_col = (blk_col == LAST_COL);
  assign last_row = (blk_row == LAST_ROW);
  assign accept   = (state == S_WAIT) && bus.in_valid;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    nb_valid   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_NB:    state_nxt = S_WAIT;
      S_WAIT: begin
        in_ready = 1'b1;
        nb_valid = 1'b1;
        if (bus.in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: if (wr_r == 2'd3) state_nxt = S_ADV;
      S_ADV: begin
        frame_done = last_col && last_row;
        state_nxt  = S_NB;
      end
      default: state_nxt = S_NB;
    endcase
  end

  // Raster order guarantees every location read here was already written in
  // the current frame; the position tests keep unavailable pixels at 0x80.
  always_comb begin
    for (int i = 0; i < 8; i++) top_d[i] = NA;
    for (int i = 0; i < 5; i++) left_d[i] = NA;
    if (blk_row != '0) begin
      for (int c = 0; c < 4; c++) top_d[c] = mem[pix_addr(y0 - 1, x0 + c)];
      for (int c = 4; c < 8; c++)
        top_d[c] = last_col ? mem[pix_addr(y0 - 1, x0 + 3)]
                            : mem[pix_addr(y0 - 1, x0 + c)];
      if (blk_col != '0) left_d[0] = mem[pix_addr(y0 - 1, x0 - 1)];
    end
    if (blk_col != '0)
      for (int r = 0; r < 4; r++) left_d[r+1] = mem[pix_addr(y0 + r, x0 - 1)];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_NB;
      wr_r    <= '0;
      blk_row <= '0;
      blk_col <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      for (int i = 0; i < 8; i++)  top_q[i] <= '0;
      for (int i = 0; i < 5; i++)  left_q[i] <= '0;
    end else begin
      state <= state_nxt;
      wr_r  <= (state == S_WRITE) ? wr_r + 2'd1 : 2'd0;
      if (accept)
        for (int i = 0; i < 16; i++) blk_q[i] <= bus.mb[i];
      if (state == S_ADV) begin
        if (last_col) begin
          blk_col <= '0;
          blk_row <= last_row ? '0 : blk_row + 1'b1;
        end else begin
          blk_col <= blk_col + 1'b1;
        end
      end
      if (state == S_NB) begin
        for (int i = 0; i < 8; i++) top_q[i] <= top_d[i];
        for (int i = 0; i < 5; i++) left_q[i] <= left_d[i];
      end
      // Reads sample the array before this edge's write: old data on collision.
      if (bus.rd_en) rd_q <= mem[bus.rd_addr];
    end
  end

  // No reset on the frame memory: an aborted frame leaves its rows in place.
  always_ff @(posedge clk) begin
    if (state == S_WRITE)
      for (int c = 0; c < 4; c++)
        mem[pix_addr(y0 + int'(wr_r), x0 + c)] <= blk_q[{wr_r, 2'(c)}];
  end

  assign bus.in_ready   = in_ready;
  assign bus.nb_valid   = nb_valid;
  assign bus.frame_done = frame_done;
  assign bus.blk_row    = blk_row;
  assign bus.blk_col    = blk_col;
  assign bus.nb_top     = top_q;
  assign bus.nb_left    = left_q;
  assign bus.rd_data    = rd_q;
endmodule

// File: tb/tb_recon_frame_store.sv
// Randomised bench for recon_frame_store against a pixel-array reference of
// the frame and the H.264 neighbour availability rules.
module tb_recon_frame_store;
  localparam int BL = 15, LEN = 16, WID = 16, COLS = LEN/4, ROWS = WID/4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  recon_frame_store_if #(.BIT_LENGTH(BL), .LENGTH(LEN), .WIDTH(WID)) bus();

  recon_frame_store #(.BIT_LENGTH(BL), .LENGTH(LEN), .WIDTH(WID),
                      .MB_SIZE_L(4), .MB_SIZE_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] ref_mem [LEN*WID];
  int m_row = 0, m_col = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] px(input int y, input int x);
    return ref_mem[y*LEN + x];
  endfunction

  // Packed as A..H, M, I..L from most to least significant byte.
  function automatic logic [103:0] exp_nb(input int r, input int c);
    logic [7:0] t [8];
    logic [7:0] l [5];
    logic [103:0] v;
    int y0, x0;
    y0 = r*4; x0 = c*4;
    for (int i = 0; i < 8; i++) t[i] = 8'h80;
    for (int i = 0; i < 5; i++) l[i] = 8'h80;
    if (r > 0) begin
      for (int i = 0; i < 4; i++) t[i] = px(y0-1, x0+i);
      for (int i = 4; i < 8; i++) t[i] = (c < COLS-1) ? px(y0-1, x0+i) : t[3];
    end
    if (r > 0 && c > 0) l[0] = px(y0-1, x0-1);
    if (c > 0) for (int i = 0; i < 4; i++) l[i+1] = px(y0+i, x0-1);
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 104'(t[i]);
    for (int i = 0; i < 5; i++) v = (v << 8) | 104'(l[i]);
    return v;
  endfunction

  function automatic logic [103:0] dut_nb();
    logic [103:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 104'(bus.nb_top[i]);
    for (int i = 0; i < 5; i++) v = (v << 8) | 104'(bus.nb_left[i]);
    return v;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.nb_valid && n < 20) begin step(); n++; end
    if (!bus.nb_valid) chk("ready_timeout", 128'(bus.nb_valid), 128'(1));
  endtask

  task automatic check_pos(input string tag);
    chk({tag, "_row"}, 128'(bus.blk_row), 128'(m_row));
    chk({tag, "_col"}, 128'(bus.blk_col), 128'(m_col));
    chk({tag, "_rdy"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "_nb"}, 128'(dut_nb()), 128'(exp_nb(m_row, m_col)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"}, 128'(bus.in_ready), 128'(0));
    chk({tag, "_nbv"}, 128'(bus.nb_valid), 128'(0));
    chk({tag, "_fd"}, 128'(bus.frame_done), 128'(0));
    chk({tag, "_rd"}, 128'(bus.rd_data), 128'(0));
    chk({tag, "_pos"}, 128'({bus.blk_row, bus.blk_col}), 128'(0));
    chk({tag, "_nb"}, 128'(dut_nb()), 128'(0));
  endtask

  task automatic model_write(input logic [127:0] d, input int nrows);
    for (int i = 0; i < nrows*4; i++)
      ref_mem[(m_row*4 + i/4)*LEN + m_col*4 + i%4] = d[i*8 +: 8];
  endtask

  task automatic send_block(input logic [127:0] d, input int stall);
    logic last;
    wait_ready();
    check_pos("wait");
    repeat (stall) begin
      step();
      chk("stall_nb", 128'(dut_nb()), 128'(exp_nb(m_row, m_col)));
    end
    for (int i = 0; i < 16; i++) bus.mb[i] = d[i*8 +: 8];
    bus.in_valid = 1'b1;
    step();
    last = (m_row == ROWS-1) && (m_col == COLS-1);
    model_write(d, 4);
    if (m_col == COLS-1) begin
      m_col = 0;
      m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
    end else m_col++;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      chk("timing", 128'({bus.nb_valid, bus.frame_done}), 128'({cyc == 7, last && cyc == 5}));
      // Junk on the input while busy must be ignored.
      if (cyc < 6) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) bus.mb[i] = 8'($urandom);
      end else bus.in_valid = 1'b0;
      if (cyc < 7) step();
    end
  endtask

  task automatic rd_chk(input int a);
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'(a);
    step();
    bus.rd_en = 1'b0;
    bus.rd_addr = 8'($urandom);
    chk("rd", 128'(bus.rd_data), 128'(ref_mem[a]));
    step();
    chk("rd_hold", 128'(bus.rd_data), 128'(ref_mem[a]));
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d;
    bus.in_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    for (int i = 0; i < 16; i++) bus.mb[i] = '0;
    for (int i = 0; i < LEN*WID; i++) ref_mem[i] = 8'h80;

    repeat (3) step();
    check_reset("rst");
    reset = 1'b1;
    chk("nbv_cycle1", 128'(bus.nb_valid), 128'(0));
    step();
    chk("nbv_cycle2", 128'(bus.nb_valid), 128'(1));
    check_pos("start");
    repeat (20) begin
      step();
      chk("idle_hold", 128'({bus.nb_valid, dut_nb()}), 128'({1'b1, exp_nb(0, 0)}));
    end

    // Frame 1: directed first block, then random.
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(8'h10 + i);
    send_block(d, 0);
    chk("b01_nb", 128'(dut_nb()), 128'({64'h80808080_80808080, 40'h80_13_17_1B_1F}));
    for (int b = 1; b < 16; b++) send_block(rnd_blk(), $urandom_range(0, 2));
    wait_ready();
    check_pos("frame_wrap");
    rd_chk(255);
    rd_chk(0);
    chk("rd0_direct", 128'(bus.rd_data), 128'(8'h10));
    repeat (8) rd_chk($urandom_range(0, LEN*WID-1));

    // Frame 2: fully random.
    for (int b = 0; b < 16; b++) send_block(rnd_blk(), $urandom_range(0, 2));

    // Frame 3: abort block (0,1) with reset in its second write cycle.
    send_block(rnd_blk(), 0);
    wait_ready();
    check_pos("abort_wait");
    d = rnd_blk();
    for (int i = 0; i < 16; i++) bus.mb[i] = d[i*8 +: 8];
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_reset("abort");
    model_write(d, 1);
    m_row = 0; m_col = 0;
    repeat (2) step();
    reset = 1'b1;
    chk("abort_nbv1", 128'(bus.nb_valid), 128'(0));
    step();
    chk("abort_nbv2", 128'(bus.nb_valid), 128'(1));
    check_pos("abort_restart");
    for (int x = 4; x < 8; x++) begin
      rd_chk(0*LEN + x);
      rd_chk(2*LEN + x);
      rd_chk(3*LEN + x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/recon_frame_store.md
Name: recon_frame_store

Overview:
- Sits directly downstream of the intra reconstruction stage.
- Accepts each reconstructed 4x4 block, writes it into an on-chip reconstructed-frame memory in raster block order, and tracks the current block position.
- Produces the 13 H.264 4x4 neighbour pixels (A..H, M, I..L) for the next block, taken from reconstructed data, for the prediction stage.
- Also provides a registered readback port so the finished frame can be read out.

Parameters:
- BIT_LENGTH, 15: MSB index of the block position counters (counters are BIT_LENGTH+1 bits wide).
- LENGTH, 16: frame row length in pixels (row stride); must be a multiple of 4.
- WIDTH, 16: frame height in rows; must be a multiple of 4.
- MB_SIZE_L, 4: block height; only 4 is supported.
- MB_SIZE_W, 4: block width; only 4 is supported.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  reconstructed block present on mb.
- in_ready  out  1  block may be accepted this cycle.
- mb  in  8 x16 (unpacked [15:0])  reconstructed block, row-major: mb[r*4+c] = pixel (row r, col c).
- nb_valid  out  1  neighbour outputs valid for block (blk_row, blk_col).
- nb_top  out  8 x8 (unpacked [7:0])  A..H, index 0 = A.
- nb_left  out  8 x5 (unpacked [4:0])  index 0 = M, 1..4 = I..L.
- blk_row  out  BIT_LENGTH+1  current block row.
- blk_col  out  BIT_LENGTH+1  current block column.
- frame_done  out  1  one-cycle pulse after the last block of a frame is written.
- rd_en  in  1  readback request.
- rd_addr  in  $clog2(LENGTH*WIDTH)  pixel address, y*LENGTH + x.
- rd_data  out  8  readback pixel, registered.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to S_NB; blk_row = blk_col = 0.
  - in_ready, nb_valid, frame_done and rd_data are 0; nb_top and nb_left are all 0.
  - Any captured block is discarded. Memory contents are NOT cleared; partially written rows remain.
  - Simulation-only memory init is 8'h80.
- FSM:
  - S_NB (1 cycle): compute and register the neighbours; go to S_WAIT.
  - S_WAIT: in_ready = 1 and nb_valid = 1; outputs hold stable indefinitely. When in_valid & in_ready, capture all 16 mb pixels into an internal register and go to S_WRITE.
  - S_WRITE (4 cycles, r = 0..3): write captured pixels r*4..r*4+3 to (y0+r)*LENGTH + x0..x0+3, where y0 = 4*blk_row and x0 = 4*blk_col. Go to S_ADV after r = 3.
  - S_ADV (1 cycle): advance the counters; go to S_NB.
- in_valid is ignored outside S_WAIT. in_ready and nb_valid are 0 in every state except S_WAIT.
- Counter advance:
  - blk_col increments; when blk_col == LENGTH/4-1 it wraps to 0 and blk_row increments.
  - When blk_row == WIDTH/4-1 also wraps, blk_row goes to 0 and frame_done = 1 for that S_ADV cycle only.
- Timing:
  - Acceptance edge at cycle k: S_WRITE k+1..k+4, S_ADV k+5, S_NB k+6, nb_valid = 1 in k+7.
  - Throughput is one block per 7 cycles.
  - After reset release, nb_valid = 1 in the second cycle.
- Neighbour rules (unavailable = 8'h80):
  - A..D: pixels (y0-1, x0..x0+3) if blk_row > 0.
  - E..H:
    - blk_row == 0: all 8'h80.
    - blk_row > 0 and blk_col < LENGTH/4-1: pixels (y0-1, x0+4..x0+7).
    - blk_row > 0 and blk_col == LENGTH/4-1: all equal D.
  - M: pixel (y0-1, x0-1) only if blk_row > 0 AND blk_col > 0.
  - I..L: pixels (y0..y0+3, x0-1) if blk_col > 0.
  - At the first block of a new frame, all neighbours are 8'h80 regardless of memory contents.
- Readback:
  - rd_en registers mem[rd_addr] into rd_data on the next edge; rd_data holds when rd_en = 0.
  - Readback works in any state.
  - A same-cycle read and write to the same address returns the old data.

Test Plan:
- Release reset, hold in_valid = 0 -> nb_valid = 1 in the second cycle; blk_row/blk_col = 0/0; all 13 neighbours 0x80; outputs stable over 20 cycles of stall.
- Send block (0,0) with mb[i] = 0x10+i, accepted at cycle k -> nb_valid low k+1..k+6, high at k+7. Block (0,1): I..L = 0x13, 0x17, 0x1B, 0x1F; A..H and M = 0x80.
- 16x16 frame: send blocks (0,0)..(0,3) with distinct values -> at (1,0): A..D = bottom row of (0,0), E..H = bottom row of (0,1), M and I..L = 0x80. At (1,1): M = pixel (3,3) of block (0,0).
- Advance to block (1,3) -> E..H all equal D (pixel (3,15)).
- Send 16 blocks -> frame_done high for exactly one cycle, 5 cycles after the 16th acceptance; counters return to 0/0; neighbours all 0x80. rd_addr = 255 returns the 16th block's mb[15]; rd_addr = 0 returns block 0's mb[0].
- Assert reset during the second S_WRITE cycle of block (0,1) -> all outputs immediately at reset values. Readback shows row 0 of that block written and rows 2..3 not written. After release, blk 0/0 with nb_valid = 1.
